canonical_huffman_decoder: RTL and testbench
============================================

# canonical_huffman_decoder

Bit-serial canonical Huffman decoder: the receive-side counterpart of the encoder path, whose sort network orders symbols by code length and then symbol value. It holds a per-length code count table and a canonical-order symbol table, both loaded by the host. It consumes a codeword bitstream one bit per cycle, MSB of each codeword first, and emits one decoded symbol per codeword over a valid/ready handshake. It sits between the bitstream unpacker and the symbol sink.

## Interface
- `SYM_W`, 8: symbol width.
- `NUM_SYM`, 256: symbol table depth; `NUM_SYM` ≤ 2^`SYM_W`.
- `MAX_LEN`, 15: longest legal code length.
- `CNT_W`, $clog2(NUM_SYM+1): width of per-length counts and symbol index.
- `LEN_W`, $clog2(MAX_LEN+1): width of length fields.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `cfg_we` in 1: write `cfg_count` into `bl_count[cfg_len]`.
- `cfg_len` in LEN_W: code length 1..MAX_LEN; writes to 0 are ignored.
- `cfg_count` in CNT_W: number of codes of that length.
- `sym_we` in 1: write the symbol table.
- `sym_addr` in CNT_W: canonical index.
- `sym_data` in SYM_W: symbol value.
- `start` in 1: enter decoding with cleared codeword state.
- `flush` in 1: return to IDLE.
- `bits_valid` in 1 / `bits_in` in 1 / `bits_ready` out 1: bitstream handshake.
- `sym_valid` out 1 / `sym_out` out SYM_W / `sym_ready` in 1: symbol handshake.
- `err` out 1: sticky invalid-codeword flag.

## Operation
- States:
  - IDLE: the only state that accepts writes. `cfg_we` and `sym_we` are ignored in every other state.
  - DECODE, OUTPUT, ERROR.
- Codeword registers:
  - `code`, MAX_LEN bits.
  - `first`, MAX_LEN+1 bits.
  - `index`, CNT_W+1 bits.
  - `len`, LEN_W bits.
  - Cleared values: code=0, first=0, index=0, len=1.
- On each accepted bit in DECODE:
  - c = (code<<1)|bits_in.
  - If c−first < bl_count[len], compare unsigned, full width: latch `sym_out` = sym_table[index + c − first], then go to OUTPUT.
  - Otherwise: index += bl_count[len]; first = (first + bl_count[len])<<1; code = c; len += 1.
  - If `len` would exceed MAX_LEN without a match, go to ERROR and set `err`=1.
- After a match, the codeword registers are cleared for the next codeword.
- OUTPUT: `sym_valid`=1 and `sym_out` are held stable until `sym_valid & sym_ready`, then the block returns to DECODE.
- ERROR: `bits_ready`=0 and `sym_valid`=0. Exit only by `start`, `flush` or `rst`.
- Priority: `rst` > `flush` > `start`.
  - `flush` in any state → IDLE. Clears the codeword registers, discards any pending symbol, clears `err`.
  - `start` in any state → DECODE with cleared codeword registers, `sym_valid`=0, `err`=0.
- The table contents are not range-checked. An over-subscribed or under-subscribed table is the loader's fault; under-subscription manifests as `err`.

## Timing
- Reset values:
  - state IDLE.
  - `bits_ready`=0, `sym_valid`=0, `sym_out`=0, `err`=0.
  - All `bl_count` entries = 0.
  - The symbol table is not reset.
  - Codeword registers cleared.
- `bits_ready` = 1 exactly in DECODE. It is a registered state decode with no combinational path from `sym_ready`.
- A bit is accepted in the cycle where `bits_valid & bits_ready`.
- Latency: last bit of a codeword accepted in cycle N → `sym_valid`=1 in cycle N+1.
- After the symbol handshake in cycle M, `bits_ready`=1 in cycle M+1.
- Throughput: L+1 cycles per length-L codeword with sym_ready held high.
- The ERROR entry and `err`=1 are visible the cycle after the MAX_LEN-th unmatched bit.
- Table writes take effect the next cycle. Simultaneous `cfg_we` and `sym_we` are both performed.
- `start` in the same cycle as an accepted bit: the bit is discarded.

## Structure
- A shared package `huffman_pkg` holds:
  - the `SYM_W`/`MAX_LEN` defaults;
  - the state enum `dec_state_t` (IDLE, DECODE, OUTPUT, ERROR);
  - the codeword register struct.
- Sub-module `huffman_sym_table`: NUM_SYM×SYM_W register array with one write port and one combinational read port.
- The count table and the FSM stay in the top.

## Test plan
- Load counts len1=1, len2=1, len3=2 and symbols 0x41,0x42,0x43,0x44. Stream 0,1,0,1,1,0,1,1,1 → symbols 0x41,0x42,0x43,0x44, each `sym_valid` exactly one cycle after its last bit.
- Flat table: len8=256, sym[i]=i. Stream 0xA5 MSB-first with `sym_ready`=1 → `sym_out`=0xA5 in cycle 9, `bits_ready`=1 again in cycle 10.
- Backpressure: hold `sym_ready`=0 for 3 cycles after a symbol with `bits_valid`=1 → `sym_valid`/`sym_out` stable, `bits_ready`=0, no bits consumed, next symbol decodes correctly.
- Under-subscribed table (len1=1 only): stream '1' followed by zeros → `err`=1 the cycle after the 15th accepted bit, `bits_ready`=0. A `start` pulse then clears `err`, and a '0' decodes sym[0].
- Mid-codeword events, using the first test's table:
  - After bits '1','1': `start` → the next bits '0' decode 0x41.
  - After bits '1','1': `rst` → all outputs zero, counts zero. `start` plus a '0' bit then gives `err` after 15 bits.
- `cfg_we` while in DECODE, len1 count set to 0 → ignored; a subsequent '0' still decodes 0x41.

Source files
------------

// File: rtl/huffman_pkg.sv
// Shared types for the canonical Huffman decoder: default widths, FSM states
// and the per-codeword tracking registers.
package huffman_pkg;

  localparam int SYM_W_DEF   = 8;
  localparam int NUM_SYM_DEF = 256;
  localparam int MAX_LEN_DEF = 15;
  localparam int CNT_W_DEF   = $clog2(NUM_SYM_DEF + 1);
  localparam int LEN_W_DEF   = $clog2(MAX_LEN_DEF + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    OUTPUT = 2'd2,
    ERROR  = 2'd3
  } dec_state_t;

  typedef struct packed {
    logic [MAX_LEN_DEF-1:0] code;
    logic [MAX_LEN_DEF:0]   first;
    logic [CNT_W_DEF:0]     index;
    logic [LEN_W_DEF-1:0]   len;
  } cw_t;

  function automatic cw_t cw_clear();
    cw_t c;
    c     = '0;
    c.len = LEN_W_DEF'(1);
    return c;
  endfunction

endpackage

// File: rtl/huffman_sym_table.sv
// Canonical-order symbol table: one synchronous write port, one combinational
// read port. Reads past the populated depth return zero.
module huffman_sym_table #(
  parameter int SYM_W   = 8,
  parameter int NUM_SYM = 256,
  parameter int ADDR_W  = 9
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [SYM_W-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [SYM_W-1:0]  rdata_o
);

  localparam int AW = (NUM_SYM > 1) ? $clog2(NUM_SYM) : 1;

  logic [SYM_W-1:0] mem_q [NUM_SYM];

  always_ff @(posedge clk) begin
    if (we_i && (waddr_i < ADDR_W'(NUM_SYM))) begin
      mem_q[waddr_i[AW-1:0]] <= wdata_i;
    end
  end

  always_comb begin
    rdata_o = '0;
    if (raddr_i < ADDR_W'(NUM_SYM)) begin
      rdata_o = mem_q[raddr_i[AW-1:0]];
    end
  end

endmodule

// File: rtl/canonical_huffman_decoder.sv
// Bit-serial canonical Huffman decoder: walks code lengths one bit at a time,
// tracking the first canonical code and table index of the current length.
module canonical_huffman_decoder
  import huffman_pkg::*;
#(
  parameter int SYM_W   = SYM_W_DEF,
  parameter int NUM_SYM = NUM_SYM_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int CNT_W   = $clog2(NUM_SYM + 1),
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             sym_we,
  input  logic [CNT_W-1:0] sym_addr,
  input  logic [SYM_W-1:0] sym_data,
  input  logic             start,
  input  logic             flush,
  input  logic             bits_valid,
  input  logic             bits_in,
  output logic             bits_ready,
  output logic             sym_valid,
  output logic [SYM_W-1:0] sym_out,
  input  logic             sym_ready,
  output logic             err
);

  dec_state_t       state_q, state_d;
  cw_t              cw_q, cw_d;
  logic [SYM_W-1:0] sym_q, sym_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] bl_count_q [MAX_LEN+1];

  logic [CNT_W-1:0] cnt_w;
  logic [MAX_LEN:0] cnt_ext;
  logic [MAX_LEN:0] c_w;
  logic [MAX_LEN:0] diff_w;
  logic             hit;
  logic [CNT_W-1:0] rd_addr;
  logic [SYM_W-1:0] rd_data;

  huffman_sym_table #(
    .SYM_W  (SYM_W),
    .NUM_SYM(NUM_SYM),
    .ADDR_W (CNT_W)
  ) u_sym_table (
    .clk    (clk),
    .we_i   (sym_we && (state_q == IDLE)),
    .waddr_i(sym_addr),
    .wdata_i(sym_data),
    .raddr_i(rd_addr),
    .rdata_o(rd_data)
  );

  // Candidate code c matches at this length when it lies inside
  // [first, first + count); its table slot is index + (c - first).
  always_comb begin
    cnt_w   = bl_count_q[cw_q.len];
    cnt_ext = {{(MAX_LEN + 1 - CNT_W){1'b0}}, cnt_w};
    c_w     = {cw_q.code, bits_in};
    diff_w  = c_w - cw_q.first;
    hit     = diff_w < cnt_ext;
    rd_addr = cw_q.index[CNT_W-1:0] + diff_w[CNT_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    cw_d    = cw_q;
    sym_d   = sym_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: ;
      DECODE: begin
        if (bits_valid) begin
          if (hit) begin
            sym_d   = rd_data;
            cw_d    = cw_clear();
            state_d = OUTPUT;
          end else if (cw_q.len == LEN_W'(MAX_LEN)) begin
            state_d = ERROR;
            err_d   = 1'b1;
          end else begin
            cw_d.index = cw_q.index + {1'b0, cnt_w};
            cw_d.first = (cw_q.first + cnt_ext) << 1;
            cw_d.code  = c_w[MAX_LEN-1:0];
            cw_d.len   = cw_q.len + LEN_W'(1);
          end
        end
      end
      OUTPUT: begin
        if (sym_ready) state_d = DECODE;
      end
      ERROR: ;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      cw_d    = cw_clear();
      err_d   = 1'b0;
    end else if (start) begin
      state_d = DECODE;
      cw_d    = cw_clear();
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cw_q    <= cw_clear();
      sym_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i <= MAX_LEN; i++) bl_count_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cw_q    <= cw_d;
      sym_q   <= sym_d;
      err_q   <= err_d;
      if (cfg_we && (state_q == IDLE) && (cfg_len != '0)) begin
        bl_count_q[cfg_len] <= cfg_count;
      end
    end
  end

  assign bits_ready = (state_q == DECODE);
  assign sym_valid  = (state_q == OUTPUT);
  assign sym_out    = sym_q;
  assign err        = err_q;

endmodule

// File: tb/tb_canonical_huffman_decoder.sv
// Bench for canonical_huffman_decoder: directed scenarios plus randomized
// bitstreams checked against a codebook-lookup reference model.
module tb_canonical_huffman_decoder;

  localparam int SYM_W = 8;
  localparam int CNT_W = 9;
  localparam int LEN_W = 4;
  localparam int MAXL  = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_we;
  logic [LEN_W-1:0] cfg_len;
  logic [CNT_W-1:0] cfg_count;
  logic             sym_we;
  logic [CNT_W-1:0] sym_addr;
  logic [SYM_W-1:0] sym_data;
  logic             start;
  logic             flush;
  logic             bits_valid;
  logic             bits_in;
  logic             bits_ready;
  logic             sym_valid;
  logic [SYM_W-1:0] sym_out;
  logic             sym_ready;
  logic             err;

  canonical_huffman_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_len   (cfg_len),
    .cfg_count (cfg_count),
    .sym_we    (sym_we),
    .sym_addr  (sym_addr),
    .sym_data  (sym_data),
    .start     (start),
    .flush     (flush),
    .bits_valid(bits_valid),
    .bits_in   (bits_in),
    .bits_ready(bits_ready),
    .sym_valid (sym_valid),
    .sym_out   (sym_out),
    .sym_ready (sym_ready),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: table contents, derived codebook, and decode progress.
  int mcnt [MAXL+1];
  int msym [256];
  int ent_len [256];
  int ent_code [256];
  int nent;
  int mcur, mlen, mout;
  bit mpend, merr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic build_codes();
    int code = 0;
    int idx = 0;
    for (int l = 1; l <= MAXL; l++) begin
      for (int k = 0; k < mcnt[l]; k++) begin
        if (idx < 256) begin
          ent_len[idx]  = l;
          ent_code[idx] = code;
          idx++;
        end
        code++;
      end
      code = code << 1;
    end
    nent = idx;
  endtask

  task automatic model_clear();
    mcur = 0; mlen = 0; mpend = 1'b0; merr = 1'b0;
  endtask

  task automatic model_bit(input int b);
    bit found = 1'b0;
    mcur = (mcur << 1) | b;
    mlen++;
    for (int i = 0; i < nent; i++) begin
      if (!found && ent_len[i] == mlen && ent_code[i] == mcur) begin
        found = 1'b1;
        mout  = msym[i];
      end
    end
    if (found) begin
      mpend = 1'b1; mcur = 0; mlen = 0;
    end else if (mlen == MAXL) begin
      merr = 1'b1;
    end
  endtask

  task automatic do_flush();
    flush = 1'b1; tick(); flush = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
    model_clear();
  endtask

  // Writes counts and symbols together so both write ports fire in one cycle.
  task automatic load_table();
    for (int i = 0; i < 256; i++) begin
      sym_we   = 1'b1;
      sym_addr = CNT_W'(i);
      sym_data = SYM_W'(msym[i]);
      cfg_we   = (i < MAXL);
      cfg_len  = LEN_W'(i + 1);
      cfg_count = CNT_W'((i < MAXL) ? mcnt[i+1] : 0);
      tick();
    end
    sym_we = 1'b0; cfg_we = 1'b0;
    build_codes();
  endtask

  task automatic set_table_a();
    for (int l = 0; l <= MAXL; l++) mcnt[l] = 0;
    for (int i = 0; i < 256; i++) msym[i] = 0;
    mcnt[1] = 1; mcnt[2] = 1; mcnt[3] = 2;
    msym[0] = 'h41; msym[1] = 'h42; msym[2] = 'h43; msym[3] = 'h44;
  endtask

  task automatic send_bit(input logic b);
    int t = 0;
    while (!bits_ready && t < 50) begin
      tick(); t++;
    end
    if (!bits_ready) check("bits_ready_timeout", 32'(bits_ready), 32'd1);
    bits_valid = 1'b1; bits_in = b;
    tick();
    bits_valid = 1'b0;
  endtask

  task automatic decode_expect(input logic [15:0] val, input int n, input int exp_sym, input string tag);
    for (int k = n - 1; k >= 0; k--) begin
      send_bit(val[k]);
      if (k > 0) check({tag, "_midvalid"}, 32'(sym_valid), 32'd0);
    end
    check({tag, "_valid"}, 32'(sym_valid), 32'd1);
    check({tag, "_sym"}, 32'(sym_out), 32'(exp_sym));
  endtask

  task automatic random_run(input int cycles, input string tag);
    for (int cyc = 0; cyc < cycles; cyc++) begin
      check({tag, "_sym_valid"}, 32'(sym_valid), 32'(mpend));
      check({tag, "_bits_ready"}, 32'(bits_ready), 32'(!mpend && !merr));
      check({tag, "_err"}, 32'(err), 32'(merr));
      if (mpend) check({tag, "_sym_out"}, 32'(sym_out), 32'(mout));
      bits_valid = ($urandom_range(0, 3) != 0);
      bits_in    = 1'($urandom_range(0, 1));
      sym_ready  = ($urandom_range(0, 2) != 0);
      start      = (merr && $urandom_range(0, 3) == 0) || ($urandom_range(0, 99) == 0);
      @(posedge clk);
      if (start) model_clear();
      else if (merr) ;
      else if (mpend) begin
        if (sym_ready) mpend = 1'b0;
      end else if (bits_valid) model_bit(int'(bits_in));
      #1;
    end
    bits_valid = 1'b0; start = 1'b0; sym_ready = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cap, total, hi, n;
    rst = 1'b1; cfg_we = 1'b0; cfg_len = '0; cfg_count = '0;
    sym_we = 1'b0; sym_addr = '0; sym_data = '0; start = 1'b0; flush = 1'b0;
    bits_valid = 1'b0; bits_in = 1'b0; sym_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_bits_ready", 32'(bits_ready), 32'd0);
    check("rst_sym_valid", 32'(sym_valid), 32'd0);
    check("rst_sym_out", 32'(sym_out), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // Small table: codes 0, 10, 110, 111.
    set_table_a(); load_table(); do_start();
    decode_expect(16'b0, 1, 'h41, "a0");
    decode_expect(16'b10, 2, 'h42, "a1");
    decode_expect(16'b110, 3, 'h43, "a2");
    decode_expect(16'b111, 3, 'h44, "a3");

    // Flat 8-bit table.
    do_flush();
    for (int l = 0; l <= MAXL; l++) mcnt[l] = 0;
    mcnt[8] = 256;
    for (int i = 0; i < 256; i++) msym[i] = i;
    load_table(); do_start();
    decode_expect(16'hA5, 8, 'hA5, "flat");
    tick();
    check("flat_ready_again", 32'(bits_ready), 32'd1);

    // Backpressure while bits are offered.
    sym_ready = 1'b0;
    decode_expect(16'h5C, 8, 'h5C, "bp");
    bits_valid = 1'b1; bits_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_hold_valid", 32'(sym_valid), 32'd1);
      check("bp_hold_sym", 32'(sym_out), 32'h5C);
      check("bp_hold_ready", 32'(bits_ready), 32'd0);
    end
    bits_valid = 1'b0; sym_ready = 1'b1;
    tick();
    check("bp_release_ready", 32'(bits_ready), 32'd1);
    decode_expect(16'h3C, 8, 'h3C, "bp_next");

    // Under-subscribed: only one length-1 code.
    do_flush();
    for (int l = 0; l <= MAXL; l++) mcnt[l] = 0;
    mcnt[1] = 1; msym[0] = 'h5A;
    load_table(); do_start();
    for (int k = 0; k < MAXL; k++) begin
      send_bit(k == 0);
      if (k == MAXL - 2) check("under_err_early", 32'(err), 32'd0);
    end
    check("under_err", 32'(err), 32'd1);
    check("under_ready", 32'(bits_ready), 32'd0);
    check("under_sym_valid", 32'(sym_valid), 32'd0);
    do_start();
    check("under_err_cleared", 32'(err), 32'd0);
    check("under_ready_back", 32'(bits_ready), 32'd1);
    decode_expect(16'b0, 1, 'h5A, "under_sym0");

    // Mid-codeword start, and start coinciding with an accepted bit.
    do_flush(); set_table_a(); load_table(); do_start();
    send_bit(1'b1); send_bit(1'b1);
    do_start();
    decode_expect(16'b0, 1, 'h41, "mid_start");
    tick();
    send_bit(1'b1);
    bits_valid = 1'b1; bits_in = 1'b1; start = 1'b1;
    tick();
    bits_valid = 1'b0; start = 1'b0;
    decode_expect(16'b0, 1, 'h41, "start_drops_bit");

    // Mid-codeword reset wipes the count table.
    tick();
    send_bit(1'b1); send_bit(1'b1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mrst_bits_ready", 32'(bits_ready), 32'd0);
    check("mrst_sym_valid", 32'(sym_valid), 32'd0);
    check("mrst_sym_out", 32'(sym_out), 32'd0);
    check("mrst_err", 32'(err), 32'd0);
    do_start();
    for (int k = 0; k < MAXL; k++) begin
      send_bit(1'b0);
      if (k == MAXL - 2) check("mrst_err_early", 32'(err), 32'd0);
    end
    check("mrst_counts_zero_err", 32'(err), 32'd1);

    // Config writes outside IDLE are ignored.
    do_flush();
    check("flush_err_cleared", 32'(err), 32'd0);
    set_table_a(); load_table(); do_start();
    cfg_we = 1'b1; cfg_len = 4'd1; cfg_count = '0;
    tick();
    cfg_we = 1'b0;
    decode_expect(16'b0, 1, 'h41, "cfg_in_decode");
    tick();

    // Randomized streams over three tables.
    random_run(400, "rnd_a");
    do_flush(); for (int l = 0; l <= MAXL; l++) mcnt[l] = 0;
    mcnt[8] = 256; for (int i = 0; i < 256; i++) msym[i] = i;
    load_table(); do_start();
    random_run(400, "rnd_flat");
    for (int t = 0; t < 3; t++) begin
      do_flush();
      cap = 2; total = 0;
      for (int l = 0; l <= MAXL; l++) mcnt[l] = 0;
      for (int l = 1; l <= 10; l++) begin
        hi = (cap < 256 - total) ? cap : 256 - total;
        n = (hi > 0) ? int'($urandom_range(0, hi)) : 0;
        mcnt[l] = n; total += n; cap = (cap - n) * 2;
      end
      for (int i = 0; i < 256; i++) msym[i] = int'($urandom_range(0, 255));
      load_table(); do_start();
      random_run(400, "rnd_tab");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
